// File: rtl/wb_sb_pkg.sv
// Shared definitions for the writeback scoreboard: FU ids, default
// latencies, slot record layout and hazard bit positions.
package wb_sb_pkg;

  localparam int unsigned NUM_FU_DEF = 5;
  localparam int unsigned FU_W_DEF   = 3;
  localparam int unsigned NREG_DEF   = 32;
  localparam int unsigned REG_W_DEF  = 5;
  localparam int unsigned DEPTH_DEF  = 32;
  localparam int unsigned LAT_W_DEF  = 5;

  localparam logic [2:0] FU_NONE = 3'd0;
  localparam logic [2:0] FU_ALU  = 3'd1;
  localparam logic [2:0] FU_MEM  = 3'd2;
  localparam logic [2:0] FU_MUL  = 3'd3;
  localparam logic [2:0] FU_DIV  = 3'd4;
  localparam logic [2:0] FU_JUMP = 3'd5;

  // Latency per FU, FU 1 in the least significant field.
  localparam logic [24:0] FU_LAT_DEF = {5'd2, 5'd24, 5'd7, 5'd2, 5'd1};

  // Slot record layout, LSB first: rd_used, rd, fu, valid.
  localparam int unsigned SLOT_USED_OFF = 0;
  localparam int unsigned SLOT_RD_OFF   = 1;

  localparam int unsigned HZ_RAW    = 0;
  localparam int unsigned HZ_WAW    = 1;
  localparam int unsigned HZ_STRUCT = 2;
  localparam int unsigned HZ_WBPORT = 3;
  localparam int unsigned HZ_W      = 4;

  function automatic int unsigned slot_fu_off(input int unsigned reg_w);
    return SLOT_RD_OFF + reg_w;
  endfunction

  function automatic int unsigned slot_valid_off(input int unsigned reg_w, input int unsigned fu_w);
    return SLOT_RD_OFF + reg_w + fu_w;
  endfunction

  function automatic int unsigned slot_width(input int unsigned reg_w, input int unsigned fu_w);
    return SLOT_RD_OFF + reg_w + fu_w + 1;
  endfunction

endpackage

// File: rtl/wb_scoreboard_timeline.sv
// Writeback slot timeline: a DEPTH-entry shift register that moves one slot
// toward the head every clock. A new entry may be dropped into any slot;
// the head entry (slot 0) is the writeback happening this cycle.
module wb_slot_timeline
  import wb_sb_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEF,
  parameter int unsigned FU_W  = FU_W_DEF,
  parameter int unsigned REG_W = REG_W_DEF,
  parameter int unsigned IDX_W = $clog2(DEPTH_DEF + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             wr_en_i,
  input  logic [IDX_W-1:0] wr_idx_i,
  input  logic [FU_W-1:0]  wr_fu_i,
  input  logic [REG_W-1:0] wr_rd_i,
  input  logic             wr_rd_used_i,
  input  logic [IDX_W-1:0] rd_idx_i,
  output logic             rd_valid_o,
  output logic             head_valid_o,
  output logic [FU_W-1:0]  head_fu_o,
  output logic [REG_W-1:0] head_rd_o,
  output logic             head_rd_used_o
);

  localparam int unsigned FU_OFF    = slot_fu_off(REG_W);
  localparam int unsigned VALID_OFF = slot_valid_off(REG_W, FU_W);
  localparam int unsigned SLOT_W    = slot_width(REG_W, FU_W);

  logic [SLOT_W-1:0] slot_q [DEPTH];
  logic [SLOT_W-1:0] slot_d [DEPTH];
  logic [SLOT_W-1:0] wr_entry_s;

  assign wr_entry_s = {1'b1, wr_fu_i, wr_rd_i, wr_rd_used_i};

  // Shift toward the head, empty slot enters at the tail, then overlay the write.
  // The write target is always empty after the shift because wbport blocks it.
  always_comb begin
    for (int i = 0; i < int'(DEPTH) - 1; i++) begin
      slot_d[i] = slot_q[i+1];
    end
    slot_d[DEPTH-1] = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      slot_d[i] = (wr_en_i && (wr_idx_i == IDX_W'(i))) ? wr_entry_s : slot_d[i];
    end
  end

  // Slot storage; reset drops every in-flight entry.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        slot_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        slot_q[i] <= slot_d[i];
      end
    end
  end

  // Occupancy lookup; an index of DEPTH (or beyond) reads as empty.
  always_comb begin
    rd_valid_o = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      rd_valid_o = (rd_idx_i == IDX_W'(i)) ? slot_q[i][VALID_OFF] : rd_valid_o;
    end
  end

  assign head_valid_o   = slot_q[0][VALID_OFF];
  assign head_fu_o      = slot_q[0][VALID_OFF-1:FU_OFF];
  assign head_rd_o      = slot_q[0][FU_OFF-1:SLOT_RD_OFF];
  assign head_rd_used_o = slot_q[0][SLOT_USED_OFF];

endmodule

// File: rtl/wb_scoreboard.sv
// In-order issue scoreboard: tracks pending destination registers, busy FUs
// and the writeback timeline, and decides whether the decoded instruction
// can issue this cycle. Writeback select outputs come from the timeline head.
module wb_scoreboard
  import wb_sb_pkg::*;
#(
  parameter int unsigned NUM_FU = NUM_FU_DEF,
  parameter int unsigned FU_W   = FU_W_DEF,
  parameter int unsigned NREG   = NREG_DEF,
  parameter int unsigned REG_W  = REG_W_DEF,
  parameter int unsigned DEPTH  = DEPTH_DEF,
  parameter int unsigned LAT_W  = LAT_W_DEF,
  parameter logic [NUM_FU*LAT_W-1:0] FU_LAT = FU_LAT_DEF
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              issue_valid_i,
  input  logic [FU_W-1:0]   issue_fu_i,
  input  logic [REG_W-1:0]  issue_rd_i,
  input  logic              issue_rd_used_i,
  input  logic [REG_W-1:0]  issue_rs1_i,
  input  logic              issue_rs1_used_i,
  input  logic [REG_W-1:0]  issue_rs2_i,
  input  logic              issue_rs2_used_i,
  input  logic              flush_i,
  output logic              issue_ready_o,
  output logic              stall_o,
  output logic [HZ_W-1:0]   hazard_o,
  output logic [NUM_FU-1:0] fu_busy_o,
  output logic              wb_valid_o,
  output logic [FU_W-1:0]   wb_fu_o,
  output logic [REG_W-1:0]  wb_rd_o,
  output logic              wb_we_o
);

  localparam int unsigned IDX_W = $clog2(DEPTH + 1);

  logic [NREG-1:0]   pending_q, pending_d;
  logic [NUM_FU-1:0] fu_busy_q, fu_busy_d;

  logic              fu_known_s;
  logic [LAT_W-1:0]  lat_s;
  logic              fu_busy_sel_s;
  logic              slot_taken_s;
  logic              raw_s, waw_s;
  logic [HZ_W-1:0]   hazard_s;
  logic              ready_s;
  logic              accept_fu_s;
  logic [IDX_W-1:0]  lat_idx_s;

  logic              head_valid_s;
  logic [FU_W-1:0]   head_fu_s;
  logic [REG_W-1:0]  head_rd_s;
  logic              head_rd_used_s;

  // Decode the requested FU id into its latency and current busy state.
  // Ids above NUM_FU are treated like "no FU".
  always_comb begin
    fu_known_s    = 1'b0;
    lat_s         = '0;
    fu_busy_sel_s = 1'b0;
    for (int i = 0; i < int'(NUM_FU); i++) begin
      fu_known_s    = (issue_fu_i == FU_W'(i + 1)) ? 1'b1 : fu_known_s;
      lat_s         = (issue_fu_i == FU_W'(i + 1)) ? FU_LAT[i*int'(LAT_W) +: LAT_W] : lat_s;
      fu_busy_sel_s = (issue_fu_i == FU_W'(i + 1)) ? fu_busy_q[i] : fu_busy_sel_s;
    end
  end

  assign lat_idx_s = IDX_W'(lat_s);

  wb_slot_timeline #(
    .DEPTH (DEPTH),
    .FU_W  (FU_W),
    .REG_W (REG_W),
    .IDX_W (IDX_W)
  ) u_timeline (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .wr_en_i        (accept_fu_s),
    .wr_idx_i       (lat_idx_s - IDX_W'(1)),
    .wr_fu_i        (issue_fu_i),
    .wr_rd_i        (issue_rd_i),
    .wr_rd_used_i   (issue_rd_used_i),
    .rd_idx_i       (lat_idx_s),
    .rd_valid_o     (slot_taken_s),
    .head_valid_o   (head_valid_s),
    .head_fu_o      (head_fu_s),
    .head_rd_o      (head_rd_s),
    .head_rd_used_o (head_rd_used_s)
  );

  // Hazard detection; no bypass, so a pending source always blocks.
  always_comb begin
    raw_s = (issue_rs1_used_i && (issue_rs1_i != '0) && pending_q[issue_rs1_i]) ||
            (issue_rs2_used_i && (issue_rs2_i != '0) && pending_q[issue_rs2_i]);
    waw_s = issue_rd_used_i && (issue_rd_i != '0) && pending_q[issue_rd_i];
    hazard_s            = '0;
    hazard_s[HZ_RAW]    = issue_valid_i & raw_s;
    hazard_s[HZ_WAW]    = issue_valid_i & waw_s;
    hazard_s[HZ_STRUCT] = issue_valid_i & fu_known_s & fu_busy_sel_s;
    hazard_s[HZ_WBPORT] = issue_valid_i & fu_known_s & slot_taken_s;
    ready_s             = issue_valid_i & ~flush_i & ~(|hazard_s);
    accept_fu_s         = ready_s & fu_known_s;
  end

  assign hazard_o      = hazard_s;
  assign issue_ready_o = ready_s;
  assign stall_o       = issue_valid_i & ~ready_s & ~flush_i;

  // Next pending/busy state: retire the head writeback, then record the new issue.
  always_comb begin
    pending_d = pending_q;
    fu_busy_d = fu_busy_q;
    for (int i = 0; i < int'(NUM_FU); i++) begin
      fu_busy_d[i] = (head_valid_s && (head_fu_s == FU_W'(i + 1))) ? 1'b0 : fu_busy_d[i];
    end
    pending_d[head_rd_s] = (head_valid_s && head_rd_used_s) ? 1'b0 : pending_d[head_rd_s];
    for (int i = 0; i < int'(NUM_FU); i++) begin
      fu_busy_d[i] = (accept_fu_s && (issue_fu_i == FU_W'(i + 1))) ? 1'b1 : fu_busy_d[i];
    end
    pending_d[issue_rd_i] = (accept_fu_s && issue_rd_used_i && (issue_rd_i != '0)) ?
                            1'b1 : pending_d[issue_rd_i];
  end

  // Pending-register and FU-busy state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pending_q <= '0;
      fu_busy_q <= '0;
    end else begin
      pending_q <= pending_d;
      fu_busy_q <= fu_busy_d;
    end
  end

  assign fu_busy_o  = fu_busy_q;
  assign wb_valid_o = head_valid_s;
  assign wb_fu_o    = head_valid_s ? head_fu_s : '0;
  assign wb_rd_o    = head_valid_s ? head_rd_s : '0;
  assign wb_we_o    = head_valid_s & head_rd_used_s;

endmodule

// File: tb/tb_wb_scoreboard.sv
// Bench for wb_scoreboard: an in-flight instruction list model checked every
// cycle, plus directed scenarios with hand-computed stall counts and values.
module tb_wb_scoreboard;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       issue_valid = 1'b0;
  logic [2:0] issue_fu = 3'd0;
  logic [4:0] issue_rd = 5'd0;
  logic       issue_rd_used = 1'b0;
  logic [4:0] issue_rs1 = 5'd0;
  logic       issue_rs1_used = 1'b0;
  logic [4:0] issue_rs2 = 5'd0;
  logic       issue_rs2_used = 1'b0;
  logic       flush = 1'b0;
  logic       issue_ready, stall, wb_valid, wb_we;
  logic [3:0] hazard;
  logic [4:0] fu_busy;
  logic [2:0] wb_fu;
  logic [4:0] wb_rd;

  wb_scoreboard dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .issue_valid_i    (issue_valid),
    .issue_fu_i       (issue_fu),
    .issue_rd_i       (issue_rd),
    .issue_rd_used_i  (issue_rd_used),
    .issue_rs1_i      (issue_rs1),
    .issue_rs1_used_i (issue_rs1_used),
    .issue_rs2_i      (issue_rs2),
    .issue_rs2_used_i (issue_rs2_used),
    .flush_i          (flush),
    .issue_ready_o    (issue_ready),
    .stall_o          (stall),
    .hazard_o         (hazard),
    .fu_busy_o        (fu_busy),
    .wb_valid_o       (wb_valid),
    .wb_fu_o          (wb_fu),
    .wb_rd_o          (wb_rd),
    .wb_we_o          (wb_we)
  );

  always #5 clk = ~clk;

  // Model: every accepted instruction occupies its FU and (if it writes a
  // nonzero rd) that register from the cycle after issue up to and including
  // its writeback cycle, which is issue cycle + latency.
  typedef struct {
    int fu;
    int rd;
    bit used;
    int wb;
  } rec_t;

  rec_t inflight[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;

  function automatic int lat_of(input int fu);
    case (fu)
      1: return 1;
      2: return 2;
      3: return 7;
      4: return 24;
      5: return 2;
      default: return 0;
    endcase
  endfunction

  function automatic logic [3:0] m_hazard();
    logic [3:0] h;
    int L;
    h = 4'b0000;
    L = lat_of(int'(issue_fu));
    if (!issue_valid) return 4'b0000;
    foreach (inflight[i]) begin
      if (inflight[i].used && inflight[i].rd != 0) begin
        if (issue_rs1_used && int'(issue_rs1) == inflight[i].rd) h[0] = 1'b1;
        if (issue_rs2_used && int'(issue_rs2) == inflight[i].rd) h[0] = 1'b1;
        if (issue_rd_used && int'(issue_rd) == inflight[i].rd) h[1] = 1'b1;
      end
      if (L > 0 && inflight[i].fu == int'(issue_fu)) h[2] = 1'b1;
      if (L > 0 && inflight[i].wb == cyc + L) h[3] = 1'b1;
    end
    return h;
  endfunction

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at t=%0t: got %0h, expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic lit(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    cmp(nm, act, exp);
  endtask

  task automatic check_cycle();
    logic [3:0] eh;
    logic       er, es, ev, ewe;
    logic [4:0] eb, erd;
    logic [2:0] ef;
    eh = m_hazard();
    er = issue_valid & ~flush & (eh == 4'b0000);
    es = issue_valid & ~er & ~flush;
    eb = 5'b0; ev = 1'b0; ef = 3'd0; erd = 5'd0; ewe = 1'b0;
    foreach (inflight[i]) begin
      eb[inflight[i].fu - 1] = 1'b1;
      if (inflight[i].wb == cyc) begin
        ev  = 1'b1;
        ef  = 3'(inflight[i].fu);
        erd = 5'(inflight[i].rd);
        ewe = inflight[i].used;
      end
    end
    n_vec++;
    cmp("hazard", 32'(hazard), 32'(eh));
    cmp("issue_ready", 32'(issue_ready), 32'(er));
    cmp("stall", 32'(stall), 32'(es));
    cmp("fu_busy", 32'(fu_busy), 32'(eb));
    cmp("wb_valid", 32'(wb_valid), 32'(ev));
    cmp("wb_fu", 32'(wb_fu), 32'(ef));
    cmp("wb_rd", 32'(wb_rd), 32'(erd));
    cmp("wb_we", 32'(wb_we), 32'(ewe));
  endtask

  // Model state update at every edge (reset clears everything at once).
  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        inflight.delete();
        cyc = 0;
      end else begin
        if (issue_valid && !flush && m_hazard() == 4'b0000 && lat_of(int'(issue_fu)) > 0) begin
          inflight.push_back('{fu: int'(issue_fu), rd: int'(issue_rd),
                               used: issue_rd_used, wb: cyc + lat_of(int'(issue_fu))});
        end
        cyc = cyc + 1;
        for (int i = inflight.size() - 1; i >= 0; i--) begin
          if (inflight[i].wb < cyc) inflight.delete(i);
        end
      end
    end
  end

  // Compare process: every falling edge.
  initial begin
    forever begin
      @(negedge clk);
      check_cycle();
    end
  end

  task automatic idle_in();
    issue_valid = 1'b0; issue_fu = 3'd0; issue_rd = 5'd0; issue_rd_used = 1'b0;
    issue_rs1 = 5'd0; issue_rs1_used = 1'b0; issue_rs2 = 5'd0; issue_rs2_used = 1'b0;
    flush = 1'b0;
  endtask

  task automatic set_in(input int fu, input int rd, input int rdu, input int rs1,
                        input int rs1u, input int rs2, input int rs2u, input int fl);
    issue_valid = 1'b1; issue_fu = 3'(fu); issue_rd = 5'(rd); issue_rd_used = 1'(rdu);
    issue_rs1 = 5'(rs1); issue_rs1_used = 1'(rs1u); issue_rs2 = 5'(rs2); issue_rs2_used = 1'(rs2u);
    flush = 1'(fl);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present an instruction (from posedge+1) until accepted; returns stall
  // cycles and the hazard seen in the first stalled cycle.
  task automatic issue_wait(input string nm, input int fu, input int rd, input int rs1,
                            input int rs1u, output int stalls, output logic [3:0] first_hz);
    bit done;
    set_in(fu, rd, 1, rs1, rs1u, 0, 0, 0);
    stalls = 0; first_hz = 4'b0000; done = 1'b0;
    for (int k = 0; k < 64 && !done; k++) begin
      @(negedge clk);
      if (issue_ready) begin
        done = 1'b1;
      end else begin
        if (stalls == 0) first_hz = hazard;
        stalls++;
      end
    end
    if (!done) begin
      n_err++;
      $display("FAIL %s_timeout: not accepted within 64 cycles", nm);
    end
    @(posedge clk);
    #1;
    idle_in();
  endtask

  int         st;
  logic [3:0] hz;

  initial begin
    // Reset state.
    repeat (2) @(negedge clk);
    lit("rst_wb_valid", 32'(wb_valid), 32'd0);
    lit("rst_fu_busy", 32'(fu_busy), 32'd0);
    lit("rst_wb_fu", 32'(wb_fu), 32'd0);
    lit("rst_wb_rd", 32'(wb_rd), 32'd0);
    lit("rst_wb_we", 32'(wb_we), 32'd0);
    #2 rst_n = 1'b1;
    idle(2);

    // 1: ALU x5, WB next cycle; nop reader of x5 waits one cycle.
    issue_wait("alu", 1, 5, 0, 0, st, hz);
    lit("t1_alu_stalls", 32'(st), 32'd0);
    lit("t1_wb_valid", 32'(wb_valid), 32'd1);
    lit("t1_wb_fu", 32'(wb_fu), 32'd1);
    lit("t1_wb_rd", 32'(wb_rd), 32'd5);
    lit("t1_wb_we", 32'(wb_we), 32'd1);
    issue_wait("nop_rd5", 0, 0, 5, 1, st, hz);
    lit("t1_raw_stalls", 32'(st), 32'd1);
    lit("t1_raw_hz", 32'(hz), 32'b0001);
    idle(3);

    // 2: MUL x3 then ADD rs1=x3: 7 RAW stall cycles.
    issue_wait("mul", 3, 3, 0, 0, st, hz);
    issue_wait("add_raw", 1, 7, 3, 1, st, hz);
    lit("t2_stalls", 32'(st), 32'd7);
    lit("t2_hz", 32'(hz), 32'b0001);
    idle(4);

    // 3: DIV x4 then MUL x4: WAW until the DIV WB cycle passes.
    issue_wait("div", 4, 4, 0, 0, st, hz);
    issue_wait("mul_waw", 3, 4, 0, 0, st, hz);
    lit("t3_stalls", 32'(st), 32'd24);
    lit("t3_hz", 32'(hz), 32'b0010);
    idle(10);

    // 4: MEM then ALU collide on the WB port.
    issue_wait("mem", 2, 8, 0, 0, st, hz);
    issue_wait("alu_wbp", 1, 9, 0, 0, st, hz);
    lit("t4_stalls", 32'(st), 32'd1);
    lit("t4_hz", 32'(hz), 32'b1000);
    lit("t4_wb_fu", 32'(wb_fu), 32'd1);
    lit("t4_wb_rd", 32'(wb_rd), 32'd9);
    idle(4);

    // 5: back-to-back DIV: structural stall of 24 cycles.
    issue_wait("div_a", 4, 10, 0, 0, st, hz);
    issue_wait("div_b", 4, 11, 0, 0, st, hz);
    lit("t5_stalls", 32'(st), 32'd24);
    lit("t5_hz", 32'(hz), 32'b0100);
    idle(28);

    // 6: flush blocks the issue without any state change.
    set_in(1, 12, 1, 0, 0, 0, 0, 1);
    @(negedge clk);
    lit("t6_flush_ready", 32'(issue_ready), 32'd0);
    lit("t6_flush_stall", 32'(stall), 32'd0);
    @(posedge clk);
    #1;
    idle_in();
    lit("t6_flush_busy", 32'(fu_busy), 32'd0);
    lit("t6_flush_wbv", 32'(wb_valid), 32'd0);

    // 6b: reset during the MUL writeback cycle drops it at once.
    issue_wait("mul_rst", 3, 13, 0, 0, st, hz);
    repeat (6) @(posedge clk);
    #1;
    lit("t6_pre_wbv", 32'(wb_valid), 32'd1);
    lit("t6_pre_busy", 32'(fu_busy), 32'b00100);
    #1 rst_n = 1'b0;
    #1;
    lit("t6_rst_wbv", 32'(wb_valid), 32'd0);
    lit("t6_rst_busy", 32'(fu_busy), 32'd0);
    lit("t6_rst_we", 32'(wb_we), 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    idle(3);
    issue_wait("alu_post", 1, 5, 0, 0, st, hz);
    lit("t6_post_stalls", 32'(st), 32'd0);
    lit("t6_post_wb_rd", 32'(wb_rd), 32'd5);
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
